data_chunk_pingpong_ctrl: RTL and testbench

//  Sequencer for the two-bank (ping-pong) data chunk store: loads one bank from the IFM loader while the other is scanned.

---
 rtl/data_chunk_pkg.sv | 37 +++
 rtl/data_chunk_pingpong_ctrl_if.sv | 50 +++++
 rtl/data_chunk_bank_status.sv | 41 ++++
 rtl/data_chunk_pingpong_ctrl.sv | 134 +++++++++++++
 tb/tb_data_chunk_pingpong_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_chunk_pkg.sv
// Shared sizing, state encodings and types for the ping-pong data chunk sequencer.
// Bank geometry is set here; every other file derives its widths from these constants.
package data_chunk_pkg;

   localparam int MEM_SIZE        = 256;
   localparam int BUS_SIZE        = 32;
   localparam int PREFIX_SUM_SIZE = 32;
   localparam int NUM_BANKS       = 2;

   localparam int WR_CYC_NUM = MEM_SIZE / BUS_SIZE;
   localparam int RD_SEG_NUM = MEM_SIZE / PREFIX_SUM_SIZE;

   // A single-entry counter still needs one bit to exist.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int WR_CNT_W = cnt_width(WR_CYC_NUM);
   localparam int SEG_W    = cnt_width(RD_SEG_NUM);

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_START,
      RD_SCAN,
      RD_RELEASE
   } rd_state_e;

   typedef enum logic {
      BANK_EMPTY = 1'b0,
      BANK_FULL  = 1'b1
   } bank_state_e;

   typedef logic [NUM_BANKS-1:0] bank_full_t;
   typedef logic [WR_CNT_W-1:0]  wr_cnt_t;
   typedef logic [SEG_W-1:0]     seg_t;

endpackage

// File: rtl/data_chunk_pingpong_ctrl_if.sv
// Loader, chunk-store and scheduler signals of the ping-pong sequencer.
// master is the sequencer side; slave is the surrounding loader/store/scheduler side.
interface data_chunk_pingpong_ctrl_if
   import data_chunk_pkg::*;
();

   logic       ld_valid_i;
   logic       ld_ready_o;
   logic       wr_valid_o;
   wr_cnt_t    wr_count_o;
   logic       wr_sel_o;
   logic       rd_en_i;
   logic       rd_sel_o;
   logic       chunk_start_o;
   seg_t       rd_sparsemap_addr_o;
   logic       pri_enc_end_i;
   logic       chunk_done_o;
   bank_full_t bank_full_o;

   modport master (
      input  ld_valid_i,
      input  rd_en_i,
      input  pri_enc_end_i,
      output ld_ready_o,
      output wr_valid_o,
      output wr_count_o,
      output wr_sel_o,
      output rd_sel_o,
      output chunk_start_o,
      output rd_sparsemap_addr_o,
      output chunk_done_o,
      output bank_full_o
   );

   modport slave (
      output ld_valid_i,
      output rd_en_i,
      output pri_enc_end_i,
      input  ld_ready_o,
      input  wr_valid_o,
      input  wr_count_o,
      input  wr_sel_o,
      input  rd_sel_o,
      input  chunk_start_o,
      input  rd_sparsemap_addr_o,
      input  chunk_done_o,
      input  bank_full_o
   );

endinterface

// File: rtl/data_chunk_bank_status.sv
// Per-bank EMPTY/FULL tracking: the writer marks a bank FULL, the reader releases it.
// Set and clear may land in the same cycle, but only on opposite banks.
module data_chunk_bank_status
   import data_chunk_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       set_en,
   input  logic       set_idx,
   input  logic       clr_en,
   input  logic       clr_idx,
   output bank_full_t full
);

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      localparam logic IDX = 1'(b);
      bank_state_e state_q;

      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= BANK_EMPTY;
         end else if (flush) begin
            state_q <= BANK_EMPTY;
         end else if (set_en && (set_idx == IDX)) begin
            state_q <= BANK_FULL;
         end else if (clr_en && (clr_idx == IDX)) begin
            state_q <= BANK_EMPTY;
         end
      end

      assign full[b] = (state_q == BANK_FULL);
   end

   a_no_set_clr_collision : assert property (
      @(posedge clk) disable iff (!rst_n)
      !(set_en && clr_en && (set_idx == clr_idx))
   );

endmodule

// File: rtl/data_chunk_pingpong_ctrl.sv
// Ping-pong sequencer: fills one data chunk bank from the IFM loader while the other
// bank is scanned segment by segment, releasing each bank after its last segment.
module data_chunk_pingpong_ctrl
   import data_chunk_pkg::*;
(
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   data_chunk_pingpong_ctrl_if.master ctrl
);

   localparam wr_cnt_t LAST_BEAT = wr_cnt_t'(WR_CYC_NUM - 1);
   localparam seg_t    LAST_SEG  = seg_t'(RD_SEG_NUM - 1);

   rd_state_e  state_q, state_d;
   seg_t       seg_q, seg_d;
   wr_cnt_t    wr_count_q;
   logic       wr_sel_q;
   logic       rd_sel_q;
   bank_full_t bank_full;

   logic ld_ready;
   logic wr_fire;
   logic last_beat;
   logic chunk_start;
   logic rd_release;

   // ---------------- write side ----------------
   assign ld_ready  = ~bank_full[wr_sel_q] & ~flush_i;
   assign wr_fire   = ctrl.ld_valid_i & ld_ready;
   assign last_beat = wr_fire & (wr_count_q == LAST_BEAT);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_count_q <= '0;
         wr_sel_q   <= 1'b0;
      end else if (flush_i) begin
         wr_count_q <= '0;
         wr_sel_q   <= 1'b0;
      end else if (wr_fire) begin
         wr_count_q <= last_beat ? '0 : wr_count_q + 1'b1;
         if (last_beat) begin
            wr_sel_q <= ~wr_sel_q;
         end
      end
   end

   // ---------------- read FSM ----------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= RD_IDLE;
         seg_q    <= '0;
         rd_sel_q <= 1'b0;
      end else begin
         state_q <= state_d;
         seg_q   <= seg_d;
         if (flush_i) begin
            rd_sel_q <= 1'b0;
         end else if (rd_release) begin
            rd_sel_q <= ~rd_sel_q;
         end
      end
   end

   // NOTE: every output of this block is given a default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      seg_d       = seg_q;
      chunk_start = 1'b0;
      rd_release  = 1'b0;

      case (state_q)
         RD_IDLE: begin
            seg_d = '0;
            if (bank_full[rd_sel_q] && ctrl.rd_en_i) begin
               state_d = RD_START;
            end
         end
         RD_START: begin
            chunk_start = 1'b1;
            seg_d       = '0;
            state_d     = RD_SCAN;
         end
         RD_SCAN: begin
            if (ctrl.pri_enc_end_i) begin
               if (seg_q == LAST_SEG) begin
                  state_d = RD_RELEASE;
               end else begin
                  seg_d = seg_q + 1'b1;
               end
            end
         end
         RD_RELEASE: begin
            rd_release = 1'b1;
            seg_d      = '0;
            state_d    = RD_IDLE;
         end
         default: begin
            state_d = RD_IDLE;
            seg_d   = '0;
         end
      endcase

      // Flush discards the in-flight scan without announcing a release.
      if (flush_i) begin
         state_d     = RD_IDLE;
         seg_d       = '0;
         chunk_start = 1'b0;
         rd_release  = 1'b0;
      end
   end

   data_chunk_bank_status u_bank_status (
      .clk     (clk_i),
      .rst_n   (rst_i),
      .flush   (flush_i),
      .set_en  (last_beat),
      .set_idx (wr_sel_q),
      .clr_en  (rd_release),
      .clr_idx (rd_sel_q),
      .full    (bank_full)
   );

   assign ctrl.ld_ready_o          = ld_ready;
   assign ctrl.wr_valid_o          = wr_fire;
   assign ctrl.wr_count_o          = wr_count_q;
   assign ctrl.wr_sel_o            = wr_sel_q;
   assign ctrl.rd_sel_o            = rd_sel_q;
   assign ctrl.chunk_start_o       = chunk_start;
   assign ctrl.rd_sparsemap_addr_o = seg_q;
   assign ctrl.chunk_done_o        = rd_release;
   assign ctrl.bank_full_o         = bank_full;

endmodule

// File: tb/tb_data_chunk_pingpong_ctrl.sv
// Directed bench for the ping-pong sequencer: a chunk-level model is compared every cycle,
// and hand-computed literal checks pin key moments of each scenario.
module tb_data_chunk_pingpong_ctrl;
   import data_chunk_pkg::*;

   logic clk = 1'b0;
   logic rst_i = 1'b0;
   logic flush_i = 1'b0;

   int checks = 0;
   int errors = 0;

   data_chunk_pingpong_ctrl_if bus ();

   data_chunk_pingpong_ctrl dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .ctrl    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- chunk-level model ----------------
   // Reader progress is a step number: -1 idle, 0 chunk start, 1..RD_SEG_NUM scanning
   // segment step-1, RD_SEG_NUM+1 releasing the bank.
   int         m_beats;
   int         m_rd_step;
   logic [1:0] m_full;
   logic       m_wr_bank;
   logic       m_rd_bank;

   task automatic model_reset();
      m_beats   = 0;
      m_rd_step = -1;
      m_full    = 2'b00;
      m_wr_bank = 1'b0;
      m_rd_bank = 1'b0;
   endtask

   initial model_reset();

   always @(negedge clk) begin
      logic       e_ready, e_wvalid, e_start, e_done;
      int         e_addr;
      logic [1:0] old_full;
      if (!rst_i) begin
         model_reset();
      end else begin
         e_ready  = !m_full[m_wr_bank] && !flush_i;
         e_wvalid = bus.ld_valid_i && e_ready;
         e_start  = (m_rd_step == 0) && !flush_i;
         e_done   = (m_rd_step == RD_SEG_NUM + 1) && !flush_i;
         if (m_rd_step == RD_SEG_NUM + 1) e_addr = RD_SEG_NUM - 1;
         else if (m_rd_step >= 1)         e_addr = m_rd_step - 1;
         else                             e_addr = 0;

         check("ld_ready",    bus.ld_ready_o,          e_ready);
         check("wr_valid",    bus.wr_valid_o,          e_wvalid);
         check("wr_count",    bus.wr_count_o,          m_beats);
         check("wr_sel",      bus.wr_sel_o,            m_wr_bank);
         check("rd_sel",      bus.rd_sel_o,            m_rd_bank);
         check("chunk_start", bus.chunk_start_o,       e_start);
         check("seg_addr",    bus.rd_sparsemap_addr_o, e_addr);
         check("chunk_done",  bus.chunk_done_o,        e_done);
         check("bank_full",   bus.bank_full_o,         m_full);

         if (flush_i) begin
            model_reset();
         end else begin
            old_full = m_full;
            if (e_wvalid) begin
               if (m_beats == WR_CYC_NUM - 1) begin
                  m_full[m_wr_bank] = 1'b1;
                  m_wr_bank         = ~m_wr_bank;
                  m_beats           = 0;
               end else begin
                  m_beats++;
               end
            end
            if (m_rd_step == -1) begin
               if (old_full[m_rd_bank] && bus.rd_en_i) m_rd_step = 0;
            end else if (m_rd_step == 0) begin
               m_rd_step = 1;
            end else if (m_rd_step == RD_SEG_NUM + 1) begin
               m_full[m_rd_bank] = 1'b0;
               m_rd_bank         = ~m_rd_bank;
               m_rd_step         = -1;
            end else if (bus.pri_enc_end_i) begin
               m_rd_step++;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic v, input logic r, input logic p);
      bus.ld_valid_i    = v;
      bus.rd_en_i       = r;
      bus.pri_enc_end_i = p;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ld_valid_i    = 1'b1;
      bus.rd_en_i       = 1'b0;
      bus.pri_enc_end_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b1;
      check("rst_ld_ready",  bus.ld_ready_o,          1);
      check("rst_wr_count",  bus.wr_count_o,          0);
      check("rst_bank_full", bus.bank_full_o,         0);
      check("rst_sels",      {bus.wr_sel_o, bus.rd_sel_o}, 0);
      check("rst_pulses",    {bus.chunk_start_o, bus.chunk_done_o}, 0);
      check("rst_seg_addr",  bus.rd_sparsemap_addr_o, 0);

      // Fill bank 0 back to back, reader already enabled.
      for (int i = 0; i < WR_CYC_NUM; i++) begin
         check("fill_count", bus.wr_count_o, i);
         step(1, 1, 0);
      end
      check("fill_wr_sel",    bus.wr_sel_o,      1);
      check("fill_bank_full", bus.bank_full_o,   2'b01);
      check("fill_no_start",  bus.chunk_start_o, 0);
      step(0, 1, 0);
      check("scan_start_t2", bus.chunk_start_o,       1);
      check("scan_addr0",    bus.rd_sparsemap_addr_o, 0);
      step(0, 0, 0);
      check("scan_start_once", bus.chunk_start_o, 0);
      for (int k = 0; k < RD_SEG_NUM; k++) begin
         check("scan_addr", bus.rd_sparsemap_addr_o, k);
         step(0, 0, 1);
         if (k < RD_SEG_NUM - 1) step(0, 0, 0);
      end
      check("scan_done",      bus.chunk_done_o, 1);
      check("scan_full_held", bus.bank_full_o,  2'b01);
      step(0, 0, 0);
      check("scan_done_once",  bus.chunk_done_o, 0);
      check("scan_rd_sel",     bus.rd_sel_o,     1);
      check("scan_bank_empty", bus.bank_full_o,  2'b00);
      step(0, 0, 1);
      check("stray_idle_addr",  bus.rd_sparsemap_addr_o, 0);
      check("stray_idle_start", bus.chunk_start_o,       0);

      // Backpressure: both banks filled with the reader disabled.
      repeat (2 * WR_CYC_NUM) step(1, 0, 0);
      check("bp_both_full", bus.bank_full_o, 2'b11);
      check("bp_wr_sel",    bus.wr_sel_o,    1);
      check("bp_not_ready", bus.ld_ready_o,  0);
      check("bp_no_write",  bus.wr_valid_o,  0);
      repeat (2) step(1, 0, 0);
      check("bp_count_held", bus.wr_count_o, 0);
      step(1, 1, 0);
      check("bp_start", bus.chunk_start_o, 1);
      step(1, 1, 0);
      repeat (RD_SEG_NUM) step(1, 1, 1);
      check("bp_release_done",     bus.chunk_done_o, 1);
      check("bp_release_notready", bus.ld_ready_o,   0);
      step(1, 1, 0);
      check("bp_freed_full",  bus.bank_full_o, 2'b01);
      check("bp_freed_ready", bus.ld_ready_o,  1);
      check("bp_rd_sel",      bus.rd_sel_o,    0);

      // Overlap: last beat into bank 1 lands in the same cycle bank 0 is released.
      for (int c = 1; c <= 10; c++) begin
         step((c <= 7) ? 1'b1 : 1'b0, 1'b1, (c >= 3) ? 1'b1 : 1'b0);
      end
      check("ovl_release",   bus.chunk_done_o, 1);
      check("ovl_count7",    bus.wr_count_o,   7);
      check("ovl_full_pre",  bus.bank_full_o,  2'b01);
      step(1, 0, 0);
      check("ovl_full_post", bus.bank_full_o,  2'b10);
      check("ovl_sels",      {bus.wr_sel_o, bus.rd_sel_o}, 2'b01);
      check("ovl_count0",    bus.wr_count_o,   0);

      // Flush in the middle of scanning bank 1.
      step(0, 1, 0);
      step(0, 0, 0);
      repeat (3) step(0, 0, 1);
      check("fl_addr3", bus.rd_sparsemap_addr_o, 3);
      flush_i = 1'b1;
      step(0, 0, 1);
      flush_i = 1'b0;
      check("fl_addr0",  bus.rd_sparsemap_addr_o, 0);
      check("fl_full",   bus.bank_full_o,         0);
      check("fl_sels",   {bus.wr_sel_o, bus.rd_sel_o}, 0);
      check("fl_nodone", bus.chunk_done_o,        0);
      step(0, 0, 1);
      check("fl_stray_addr", bus.rd_sparsemap_addr_o, 0);

      // Asynchronous reset in the middle of scanning a fresh bank 0.
      repeat (WR_CYC_NUM) step(1, 1, 0);
      step(0, 1, 0);
      step(0, 0, 0);
      repeat (3) step(0, 0, 1);
      check("ar_addr3", bus.rd_sparsemap_addr_o, 3);
      bus.pri_enc_end_i = 1'b0;
      #2;
      rst_i = 1'b0;
      #1;
      check("ar_addr0",  bus.rd_sparsemap_addr_o, 0);
      check("ar_full",   bus.bank_full_o,         0);
      check("ar_nodone", bus.chunk_done_o,        0);
      @(posedge clk);
      #1;
      rst_i = 1'b1;
      step(0, 0, 0);
      check("ar_idle_start", bus.chunk_start_o, 0);
      check("ar_idle_done",  bus.chunk_done_o,  0);
      step(0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
